// File: rtl/adder4_arb_pkg.sv
// adder4_arb_pkg
// Shared types and constants for the two-requester adder4 arbiter.
//   state_t  : controller state (IDLE / RESP)
//   REQ0/REQ1: requester identifiers, also used as the round-robin pointer value
//   NUM_REQ  : number of requesters sharing the adder
package adder4_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic REQ0    = 1'b0;
  localparam logic REQ1    = 1'b1;
  localparam int   NUM_REQ = 2;

endpackage

// File: rtl/adder4.sv
// adder4
// 4-bit ripple adder datapath: {cout, sum} = a + b + cin.
//   a, b : 4-bit operands
//   cin  : carry-in
//   sum  : 4-bit sum
//   cout : carry-out
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/adder4_arb_rr_arb2.sv
// adder4_rr_arb2
// Pure-combinational two-way round-robin grant.
//   valid0, valid1 : requests
//   last           : requester granted most recently; the other one wins a tie
//   enable         : grants are only issued while enabled
//   grant0, grant1 : one-hot (or zero) grant
module adder4_rr_arb2
  import adder4_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  input  logic enable,
  output logic grant0,
  output logic grant1
);

  assign grant0 = enable & valid0 & (~valid1 | (last == REQ1));
  assign grant1 = enable & valid1 & (~valid0 | (last == REQ0));

endmodule

// File: rtl/adder4_arb.sv
// adder4_arb
// Shares one adder4 between two requesters. A round-robin arbiter picks an
// operand set in IDLE; the result is registered and held on the owner's
// response channel until it is taken. Saturating grant counters per requester.
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid/ready/a/b/cin      : operand channel of requester N
//   rspN_valid/ready              : response handshake of requester N
//   rsp_sum, rsp_cout             : registered result, shared by both channels
//   busy                          : high while a result is held (RESP)
//   cnt0, cnt1                    : saturating grant counters
//
// state | meaning
// IDLE  | no result held, arbiter may grant
// RESP  | result held for owner, waiting for owner's rsp ready
module adder4_arb
  import adder4_arb_pkg::*;
#(
  parameter int FIRST_PRIO = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [3:0]       rsp_sum,
  output logic             rsp_cout,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  // Pointer reset so that FIRST_PRIO wins the first tie.
  localparam logic LAST_RST = (FIRST_PRIO == 0) ? REQ1 : REQ0;

  state_t             state, state_nxt;
  logic               last;
  logic               owner;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               sel;
  logic               rsp_taken;
  logic [3:0]         op_a, op_b;
  logic               op_cin;
  logic [3:0]         add_sum;
  logic               add_cout;

  adder4_rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last),
    .enable (state == IDLE),
    .grant0 (grant[REQ0]),
    .grant1 (grant[REQ1])
  );

  assign accept    = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign sel       = grant[REQ1] ? REQ1 : REQ0;
  // Only the owner's ready can retire the held result.
  assign rsp_taken = (owner == REQ1) ? rsp1_ready : rsp0_ready;

  always_comb begin
    op_a   = req0_a;
    op_b   = req0_b;
    op_cin = req0_cin;
    if (sel == REQ1) begin
      op_a   = req1_a;
      op_b   = req1_b;
      op_cin = req1_cin;
    end
  end

  adder4 u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RESP;
      RESP:    if (rsp_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req0_ready = grant[REQ0];
    req1_ready = grant[REQ1];
    busy       = (state == RESP);
    rsp0_valid = (state == RESP) & (owner == REQ0);
    rsp1_valid = (state == RESP) & (owner == REQ1);
  end

  // Result register, ownership, pointer and grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sum  <= 4'h0;
      rsp_cout <= 1'b0;
      owner    <= REQ0;
      last     <= LAST_RST;
      cnt0     <= '0;
      cnt1     <= '0;
    end else if (accept) begin
      rsp_sum  <= add_sum;
      rsp_cout <= add_cout;
      owner    <= sel;
      last     <= sel;
      if (sel == REQ0 && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
      if (sel == REQ1 && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder4_arb.sv
module tb_adder4_arb;

  localparam int CNT_W      = 2;
  localparam int FIRST_PRIO = 0;
  localparam int CMAX       = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req0_cin;
  logic [3:0]       req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_cin;
  logic [3:0]       req1_a, req1_b;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [3:0]       rsp_sum;
  logic             rsp_cout, busy;
  logic [CNT_W-1:0] cnt0, cnt1;

  adder4_arb #(.FIRST_PRIO(FIRST_PRIO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic drive_req(input bit id, input logic [3:0] a, input logic [3:0] b, input logic cin);
    if (id == 0) begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin;
    end
  endtask

  typedef struct {
    bit         id;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[6];
  int   bcnt[2];
  int   sat_exp[5];
  int   ord_id[$];
  int   ord_cyc[$];

  // reference model state
  bit   m_pend;
  int   m_owner, m_res, m_last, w;
  int   m_cnt[2];
  bit   v0, v1;

  initial begin
    rst = 1;
    idle_inputs();
    #1;
    tick();
    tick();

    // reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    rst = 0;
    tick();

    // single-requester transactions
    vecs[0] = '{0, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0};
    vecs[1] = '{1, 4'hF, 4'h1, 1'b1, 4'h1, 1'b1};
    vecs[2] = '{0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
    vecs[3] = '{1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
    vecs[4] = '{0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[5] = '{1, 4'h8, 4'h7, 1'b0, 4'hF, 1'b0};
    bcnt[0] = 0; bcnt[1] = 0;
    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(negedge clk);
      chk("vec_ready_own", vecs[i].id ? req1_ready : req0_ready, 1);
      chk("vec_ready_other", vecs[i].id ? req0_ready : req1_ready, 0);
      tick();
      req0_valid = 0; req1_valid = 0;
      if (bcnt[vecs[i].id] < CMAX) bcnt[vecs[i].id]++;
      @(negedge clk);
      chk("vec_rsp_valid", vecs[i].id ? rsp1_valid : rsp0_valid, 1);
      chk("vec_sum", rsp_sum, vecs[i].sum);
      chk("vec_cout", rsp_cout, vecs[i].cout);
      chk("vec_busy", busy, 1);
      chk("vec_cnt0", cnt0, bcnt[0]);
      chk("vec_cnt1", cnt1, bcnt[1]);
      if (vecs[i].id) rsp1_ready = 1; else rsp0_ready = 1;
      tick();
      rsp0_ready = 0; rsp1_ready = 0;
    end

    // overflow result held under backpressure; req0 waits
    drive_req(1, 4'hF, 4'h1, 1'b1);
    @(negedge clk);
    chk("ovf_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    drive_req(0, 4'h2, 4'h2, 1'b0);
    rsp0_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_rsp1_valid", rsp1_valid, 1);
      chk("hold_rsp0_valid", rsp0_valid, 0);
      chk("hold_sum", rsp_sum, 4'h1);
      chk("hold_cout", rsp_cout, 1);
      chk("hold_req0_ready", req0_ready, 0);
      tick();
    end
    rsp1_ready = 1;
    @(negedge clk);
    chk("hold_last_rsp1_valid", rsp1_valid, 1);
    tick();
    rsp1_ready = 0; rsp0_ready = 0;
    @(negedge clk);
    chk("after_hold_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    rsp1_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("nonowner_rsp0_valid", rsp0_valid, 1);
      chk("nonowner_rsp1_valid", rsp1_valid, 0);
      chk("nonowner_sum", rsp_sum, 4'h4);
      tick();
    end
    rsp1_ready = 0; rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    @(negedge clk);
    chk("nonowner_done_busy", busy, 0);
    tick();

    // contended round-robin
    do_reset();
    drive_req(0, 4'h1, 4'h1, 1'b0);
    drive_req(1, 4'h2, 4'h2, 1'b0);
    rsp0_ready = 1; rsp1_ready = 1;
    for (int c = 0; c < 16 && ord_id.size() < 4; c++) begin
      @(negedge clk);
      chk("rr_onehot", {30'b0, req1_ready, req0_ready} == 3, 0);
      if (req0_ready) begin ord_id.push_back(0); ord_cyc.push_back(c); end
      if (req1_ready) begin ord_id.push_back(1); ord_cyc.push_back(c); end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("rr_accepts", ord_id.size(), 4);
    for (int k = 0; k < ord_id.size(); k++) begin
      chk("rr_order", ord_id[k], k % 2);
      if (k > 0) chk("rr_spacing", ord_cyc[k] - ord_cyc[k-1], 2);
    end
    @(negedge clk);
    chk("rr_cnt0", cnt0, 2);
    chk("rr_cnt1", cnt1, 2);
    chk("rr_busy", busy, 0);
    tick();
    rsp0_ready = 0; rsp1_ready = 0;

    // counter saturation
    do_reset();
    sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;
    for (int k = 0; k < 5; k++) begin
      drive_req(0, 4'h1, 4'h2, 1'b0);
      tick();
      req0_valid = 0;
      @(negedge clk);
      chk("sat_cnt0", cnt0, sat_exp[k]);
      rsp0_ready = 1;
      tick();
      rsp0_ready = 0;
    end

    // reset in RESP; pointer last=0 before reset, so a tie would go to 1 without it
    drive_req(0, 4'h5, 4'h6, 1'b0);
    tick();
    req0_valid = 0;
    @(negedge clk);
    chk("mid_pre_rsp0_valid", rsp0_valid, 1);
    chk("mid_pre_sum", rsp_sum, 4'hB);
    tick();
    rst = 1;
    tick();
    rst = 0;
    drive_req(0, 4'h1, 4'h0, 1'b0);
    drive_req(1, 4'h2, 4'h0, 1'b0);
    @(negedge clk);
    chk("mid_rsp0_valid", rsp0_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sum", rsp_sum, 0);
    chk("mid_cnt0", cnt0, 0);
    chk("mid_cnt1", cnt1, 0);
    chk("mid_tie_req0_ready", req0_ready, 1);
    chk("mid_tie_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("mid_tie_rsp0_valid", rsp0_valid, 1);
    chk("mid_tie_sum", rsp_sum, 4'h1);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;

    // randomized traffic against the reference model
    do_reset();
    m_pend = 0; m_owner = 0; m_res = 0; m_last = (FIRST_PRIO == 0) ? 1 : 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_cin = 1'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_cin = 1'($urandom);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      v0 = req0_valid; v1 = req1_valid;
      w = -1;
      if (!m_pend) begin
        if (v0 && v1) w = (m_last == 0) ? 1 : 0;
        else if (v0)  w = 0;
        else if (v1)  w = 1;
      end
      chk("rand_req0_ready", req0_ready, w == 0);
      chk("rand_req1_ready", req1_ready, w == 1);
      chk("rand_busy", busy, m_pend);
      chk("rand_rsp0_valid", rsp0_valid, m_pend && m_owner == 0);
      chk("rand_rsp1_valid", rsp1_valid, m_pend && m_owner == 1);
      if (m_pend) chk("rand_result", {27'b0, rsp_cout, rsp_sum}, m_res);
      chk("rand_cnt0", cnt0, m_cnt[0]);
      chk("rand_cnt1", cnt1, m_cnt[1]);
      if (w >= 0) begin
        m_res = (w == 0) ? int'(req0_a) + int'(req0_b) + int'(req0_cin)
                         : int'(req1_a) + int'(req1_b) + int'(req1_cin);
        m_pend  = 1;
        m_owner = w;
        m_last  = w;
        if (m_cnt[w] < CMAX) m_cnt[w]++;
      end else if (m_pend && ((m_owner == 0) ? rsp0_ready : rsp1_ready)) begin
        m_pend = 0;
      end
      tick();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
